// File: rtl/snn_pkg.sv
// Shared definitions for the spiking front end: FSM encoding and arithmetic helpers.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^wid-1].
    function automatic logic [31:0] sat_u(input logic signed [31:0] value, input int unsigned wid);
        logic [31:0] max_v;
        max_v = 32'((64'd1 << wid) - 64'd1);
        if (value < 0)
            return '0;
        else if ($unsigned(value) > max_v)
            return max_v;
        else
            return $unsigned(value);
    endfunction

endpackage

// File: rtl/syn_weight_rf.sv
// Synaptic weight register file: synchronous write, asynchronous read-before-write.
module syn_weight_rf
    import snn_pkg::*;
#(
    parameter int unsigned W_WID = 8,
    parameter int unsigned W_NUM = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [clog2(W_NUM)-1:0]   wr_addr,
    input  logic [W_WID-1:0]          wr_data,
    input  logic [clog2(W_NUM)-1:0]   rd_addr,
    output logic [W_WID-1:0]          rd_data_c
);

    logic [W_WID-1:0] mem [W_NUM];

    // Out-of-range addresses are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(W_NUM); i++) mem[i] <= '0;
        end else if (we && (32'(wr_addr) < W_NUM)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/spike_synapse.sv
// Spike-to-current converter: weights active inputs one per cycle, then leaks and saturates the current.
module spike_synapse
    import snn_pkg::*;
#(
    parameter int unsigned W_WID = 8,
    parameter int unsigned W_NUM = 4,
    parameter int unsigned I_WID = 8,
    parameter int unsigned TAU_S = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W_NUM-1:0]          i_spike,
    input  logic                      i_spike_vld,
    output logic                      o_spike_rdy,
    input  logic                      w_we,
    input  logic [clog2(W_NUM)-1:0]   w_addr,
    input  logic [W_WID-1:0]          w_data,
    output logic [I_WID-1:0]          ir,
    output logic                      o_ir_vld
);

    localparam int unsigned A_WID   = clog2(W_NUM);
    localparam int unsigned ACC_WID = W_WID + A_WID + 1;
    localparam int unsigned NXT_WID = I_WID + W_WID + A_WID + 1;

    state_t                     state_q, state_d;
    logic [W_NUM-1:0]           spk_q, spk_d;
    logic signed [ACC_WID-1:0]  acc_q, acc_d;
    logic [A_WID-1:0]           idx_q, idx_d;
    logic [I_WID-1:0]           ir_d;
    logic                       ir_vld_d;
    logic                       rdy_d;
    logic [W_WID-1:0]           w_rd_c;
    logic signed [W_WID-1:0]    w_s;
    logic signed [NXT_WID-1:0]  cur_ext, leak_ext, acc_ext, nxt;

    syn_weight_rf #(
        .W_WID (W_WID),
        .W_NUM (W_NUM)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (w_we),
        .wr_addr   (w_addr),
        .wr_data   (w_data),
        .rd_addr   (idx_q),
        .rd_data_c (w_rd_c)
    );

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d  = state_q;
        spk_d    = spk_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        ir_d     = ir;
        ir_vld_d = 1'b0;

        w_s      = w_rd_c;
        cur_ext  = NXT_WID'(ir);
        leak_ext = NXT_WID'(ir >> TAU_S);
        acc_ext  = NXT_WID'(acc_q);
        nxt      = cur_ext - leak_ext + acc_ext;

        case (state_q)
            IDLE: begin
                if (i_spike_vld && o_spike_rdy) begin
                    spk_d   = i_spike;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (spk_q[idx_q]) acc_d = acc_q + ACC_WID'(w_s);
                if (32'(idx_q) == W_NUM - 1) state_d = UPDATE;
                else                         idx_d   = idx_q + A_WID'(1);
            end
            UPDATE: begin
                ir_d     = I_WID'(sat_u(32'(nxt), I_WID));
                ir_vld_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spk_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            ir          <= '0;
            o_ir_vld    <= 1'b0;
            o_spike_rdy <= 1'b1;
        end else begin
            state_q     <= state_d;
            spk_q       <= spk_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            ir          <= ir_d;
            o_ir_vld    <= ir_vld_d;
            o_spike_rdy <= rdy_d;
        end
    end

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse: vector table of timesteps plus hand-written corner sequences.
module tb_spike_synapse;

    logic       clk;
    logic       rst;
    logic [3:0] i_spike;
    logic       i_spike_vld;
    logic       o_spike_rdy;
    logic       w_we;
    logic [1:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] ir;
    logic       o_ir_vld;

    int n_cmp;
    int n_bad;

    spike_synapse dut (
        .clk         (clk),
        .rst         (rst),
        .i_spike     (i_spike),
        .i_spike_vld (i_spike_vld),
        .o_spike_rdy (o_spike_rdy),
        .w_we        (w_we),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .ir          (ir),
        .o_ir_vld    (o_ir_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            load;
        logic [3:0][7:0] w;
        logic [3:0]      spk;
        logic [7:0]      exp_ir;
    } vec_t;

    localparam logic [3:0][7:0] W_STD = '{8'h9C, 8'd30, 8'd20, 8'd10};
    localparam logic [3:0][7:0] W_MAX = '{8'd127, 8'd127, 8'd127, 8'd127};
    localparam logic [3:0][7:0] W_POS = '{8'd40, 8'd30, 8'd20, 8'd10};

    vec_t vecs [7];
    logic [7:0] exp5 [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_all(input logic [3:0][7:0] w);
        for (int k = 0; k < 4; k++) begin
            w_we   = 1'b1;
            w_addr = 2'(k);
            w_data = w[k];
            @(negedge clk);
        end
        w_we = 1'b0;
    endtask

    // One timestep from a negedge with rdy high; optional weight write lands on edge T+2.
    task automatic run_step(input logic [3:0] spk, input logic [7:0] exp_ir,
                            input logic wr_en, input logic [1:0] wa, input logic [7:0] wd,
                            input string tag);
        check({tag, ".rdy_pre"}, 32'(o_spike_rdy), 32'd1);
        i_spike     = spk;
        i_spike_vld = 1'b1;
        @(negedge clk);
        i_spike_vld = 1'b0;
        i_spike     = '0;
        check({tag, ".busy0"}, 32'({o_ir_vld, o_spike_rdy}), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            if (k == 2 && wr_en) begin
                w_we   = 1'b1;
                w_addr = wa;
                w_data = wd;
            end
            @(negedge clk);
            w_we = 1'b0;
            check($sformatf("%s.busy%0d", tag, k), 32'({o_ir_vld, o_spike_rdy}), 32'd0);
        end
        @(negedge clk);
        check({tag, ".vld"}, 32'(o_ir_vld), 32'd1);
        check({tag, ".rdy"}, 32'(o_spike_rdy), 32'd1);
        check({tag, ".ir"}, 32'(ir), 32'(exp_ir));
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        i_spike = '0; i_spike_vld = 1'b0;
        w_we = 1'b0; w_addr = '0; w_data = '0;
        n_cmp = 0; n_bad = 0;

        vecs[0] = '{1'b1, W_STD, 4'b0111, 8'd60};
        vecs[1] = '{1'b0, W_STD, 4'b0000, 8'd45};
        vecs[2] = '{1'b0, W_STD, 4'b1000, 8'd0};
        vecs[3] = '{1'b1, W_MAX, 4'b1111, 8'd255};
        vecs[4] = '{1'b0, W_MAX, 4'b1111, 8'd255};
        vecs[5] = '{1'b1, W_STD, 4'b0101, 8'd232};
        vecs[6] = '{1'b0, W_STD, 4'b1010, 8'd94};
        exp5[0] = 8'd81; exp5[1] = 8'd91; exp5[2] = 8'd79;

        repeat (2) @(negedge clk);
        check("reset.ir", 32'(ir), 32'd0);
        check("reset.vld", 32'(o_ir_vld), 32'd0);
        check("reset.rdy", 32'(o_spike_rdy), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed timesteps from the table.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].load) load_all(vecs[v].w);
            run_step(vecs[v].spk, vecs[v].exp_ir, 1'b0, 2'd0, 8'd0, $sformatf("vec%0d", v));
        end
        @(negedge clk);
        check("vec6.vld_drop", 32'(o_ir_vld), 32'd0);

        // Valid held high: only the vector on every sixth edge may be taken.
        for (int n = 0; n < 18; n++) begin
            i_spike_vld = 1'b1;
            if (n % 6 == 0) i_spike = ((n / 6) % 2 == 1) ? 4'b0100 : 4'b0001;
            else            i_spike = 4'b1111;
            @(negedge clk);
            check($sformatf("stream%0d.vld", n), 32'(o_ir_vld), 32'(n % 6 == 5));
            check($sformatf("stream%0d.rdy", n), 32'(o_spike_rdy), 32'(n % 6 == 5));
            if (n % 6 == 5) check($sformatf("stream%0d.ir", n), 32'(ir), 32'(exp5[n / 6]));
        end
        i_spike_vld = 1'b0;
        i_spike     = '0;

        // Reset landing on the SCAN cycle for index 2.
        load_all(W_POS);
        check("rstmid.rdy_pre", 32'(o_spike_rdy), 32'd1);
        i_spike     = 4'b1111;
        i_spike_vld = 1'b1;
        @(negedge clk);
        i_spike_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid.ir", 32'(ir), 32'd0);
        check("rstmid.rdy", 32'(o_spike_rdy), 32'd1);
        check("rstmid.vld", 32'(o_ir_vld), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rstmid.quiet%0d", k), 32'(o_ir_vld), 32'd0);
        end
        run_step(4'b1111, 8'd0, 1'b0, 2'd0, 8'd0, "rstmid.wzero");

        // Write to the index being read in the same SCAN cycle.
        load_all(W_STD);
        run_step(4'b0010, 8'd20, 1'b1, 2'd1, 8'd50, "rbw.old");
        run_step(4'b0010, 8'd65, 1'b0, 2'd0, 8'd0, "rbw.new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
Presynaptic front end for the lif neuron. It takes a W_NUM-wide spike vector per timestep and weights each active input with a programmable signed weight. It integrates the result into a leaky synaptic current and drives the neuron's 8-bit `ir` input. It is the spike-to-current converter that the lif neuron (current-to-spike) consumes from.

Parameters:
- W_WID, 8: weight width, signed two's complement.
- W_NUM, 4: number of presynaptic inputs (>=2).
- I_WID, 8: output current width, unsigned.
- TAU_S, 2: synaptic leak shift; the current decays by cur>>TAU_S per timestep.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- i_spike, input, W_NUM: presynaptic spike vector; bit k = input k fired.
- i_spike_vld, input, 1: spike vector valid.
- o_spike_rdy, output, 1: block can accept a spike vector.
- w_we, input, 1: weight write enable.
- w_addr, input, $clog2(W_NUM): weight index.
- w_data, input, W_WID: signed weight value.
- ir, output, I_WID: synaptic current to the neuron; held between updates.
- o_ir_vld, output, 1: one-cycle pulse when `ir` takes a new value.

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high, on ports `clk` and `rst`.
- Reset values: `ir`=0, `o_ir_vld`=0, `o_spike_rdy`=1, all weights=0, state=IDLE, accumulator=0, index=0.
- Reset mid-operation: an in-flight timestep is discarded with no `o_ir_vld` pulse. Reset overrides a simultaneous `w_we` or handshake.
- Handshake: a transfer occurs when `i_spike_vld` && `o_spike_rdy` at a rising edge. `o_spike_rdy`=1 only in IDLE, and it is a registered output. `i_spike_vld` outside IDLE is ignored; there is no queuing.
- FSM:
  - IDLE: on transfer, latch `i_spike` into spk_q, clear acc and idx, go to SCAN.
  - SCAN: one weight per cycle. If spk_q[idx], then acc += sign-extended w[idx]. When idx==W_NUM-1, go to UPDATE; otherwise idx++. Occupies exactly W_NUM cycles.
  - UPDATE: nxt = cur - (cur>>TAU_S) + acc, computed signed at width I_WID+W_WID+$clog2(W_NUM)+1. Saturate below 0 to 0 and above 2^I_WID-1 to 2^I_WID-1. Register the result into `ir`, pulse `o_ir_vld`, return to IDLE.
- Latency: the transfer edge is T. `ir` and `o_ir_vld` update at edge T+W_NUM+1. `o_spike_rdy` is 1 again after edge T+W_NUM+1, so the next transfer can occur at edge T+W_NUM+2. Peak throughput is one timestep per W_NUM+2 cycles.
- Leak: applied once per accepted timestep only; there is no decay while idle. An all-zero spike vector still runs SCAN and UPDATE and applies the leak.
- Weights:
  - Storage is a W_NUM x W_WID register array; writes are accepted in any state.
  - If `w_we` targets the index read in the same SCAN cycle, the old value is used (read-before-write). The new value applies from the next cycle.
  - `w_addr` >= W_NUM is ignored.
- Arithmetic: the worst-case accumulator is W_NUM*(-2^(W_WID-1)) to W_NUM*(2^(W_WID-1)-1). The accumulator never wraps, and saturation is applied only at UPDATE.

Decomposition:
- Shared package snn_pkg:
  - FSM state encoding: IDLE, SCAN, UPDATE.
  - Function clog2.
  - Saturating-clamp function sat_u(value, I_WID).
- Weight array as sub-module syn_weight_rf: sync write, async read, read-before-write semantics, synchronous reset to zero.
- FSM, accumulator and leak logic stay in spike_synapse.

Test Plan:
All scenarios use the defaults (W_WID=8, W_NUM=4, I_WID=8, TAU_S=2) and weights w = {10, 20, 30, -100} for indices 0..3, unless stated otherwise.
1. After reset, load the weights, then send i_spike=4'b0111 -> `ir`=60 with `o_ir_vld` pulsed exactly at edge T+5, and `o_spike_rdy` low for edges T+1 through T+5.
2. Follow with i_spike=4'b0000 -> `ir`=60-15=45.
3. Follow with i_spike=4'b1000 -> 45-11-100=-66, clamped to `ir`=0.
4. Set all four weights to 127 and send 4'b1111 from `ir`=0 -> acc=508, `ir`=255. Repeat -> `ir` stays 255 (255-63+508 is clamped).
5. Hold `i_spike_vld` high continuously with alternating vectors -> transfers occur only every 6 cycles, and vectors presented while rdy=0 are never accumulated.
6. Assert `rst` during the SCAN cycle at idx 2 -> no `o_ir_vld` pulse; next cycle `ir`=0, `o_spike_rdy`=1, all weights 0. Separately, write w[1]=50 in the same cycle SCAN reads idx 1 with spike 4'b0010 -> `ir`=20, and the next timestep uses 50.
